// File: rtl/uart_pkg.sv
// Shared types and frame arithmetic for the parameterised UART transmitter.
package uart_pkg;

    // Parity mode of a frame.
    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    // Transmitter state; also exported on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // Every frame opens with exactly one start bit.
    localparam int START_BITS = 1;

    // Number of bit periods in one frame for a given configuration.
    function automatic int frame_bits(input int data_bits, input parity_e par,
                                      input int stop_bits);
        return START_BITS + data_bits + ((par == PAR_NONE) ? 0 : 1) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO in front of the transmitter. Pointers carry one extra
// wrap bit so full and empty are told apart without a separate counter.
// Only instantiated when UART_TX_FIFO_EN is defined.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             push_in,
    input  logic [WIDTH-1:0] wr_data_in,
    input  logic             pop_in,
    output logic [WIDTH-1:0] rd_data_out,
    output logic             full_out,
    output logic             empty_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    // Flags, qualified strobes and pointer advance.
    always_comb begin
        empty_out   = (wr_ptr_q == rd_ptr_q);
        full_out    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        push_ok     = push_in && !full_out;
        pop_ok      = pop_in && !empty_out;
        wr_ptr_d    = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        rd_data_out = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[PTR_W-1:0]] <= wr_data_in;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start bit, DATA_BITS data bits LSB first,
// optional parity, STOP_BITS stop bits, each bit held for DIVISOR clocks.
// Handshake: a word is taken on any rising edge with valid_in && ready_out.
// Build option: define UART_TX_FIFO_EN to place a FIFO_DEPTH-deep FIFO in
// front of the transmitter (ready_out then means "FIFO not full").
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int      DIVISOR    = 868,
    parameter int      DATA_BITS  = 8,
    parameter parity_e PARITY     = PAR_NONE,
    parameter int      STOP_BITS  = 1,
    parameter int      FIFO_DEPTH = 8
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [DATA_BITS-1:0] val_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 data_out,
    output logic                 busy_out,
    output tx_state_e            state_out
);

    localparam int CNT_W = $clog2(DIVISOR);
    localparam int IDX_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

    tx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 line_q, line_d;

    logic                 load;
    logic [DATA_BITS-1:0] load_word;
    logic                 bit_end;

`ifdef UART_TX_FIFO_EN
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_rd_data;

    // The transmitter pops whenever it is idle and a word is waiting.
    assign load      = (state_q == ST_IDLE) && !fifo_empty;
    assign load_word = fifo_rd_data;
    assign ready_out = !fifo_full;

    uart_tx_fifo #(
        .WIDTH(DATA_BITS),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_in     (clk_in),
        .rst_n_in   (rst_n_in),
        .push_in    (valid_in && !fifo_full),
        .wr_data_in (val_in),
        .pop_in     (load),
        .rd_data_out(fifo_rd_data),
        .full_out   (fifo_full),
        .empty_out  (fifo_empty)
    );
`else
    // Direct mode: only an idle transmitter accepts a word.
    assign load      = (state_q == ST_IDLE) && valid_in;
    assign load_word = val_in;
    assign ready_out = (state_q == ST_IDLE);

    // FIFO_DEPTH has no effect in this build; referenced so it stays in the interface.
    if (FIFO_DEPTH < 2) begin : g_fifo_depth_unused
    end
`endif

    assign bit_end = (cnt_q == CNT_LAST);

    // State and datapath registers; reset returns the line to idle-high.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic: each state ends on the last clock of its bit period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (load) state_d = ST_START;
            ST_START:  if (bit_end) state_d = ST_DATA;
            ST_DATA:   if (bit_end && (idx_q == DATA_LAST))
                           state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
            ST_PARITY: if (bit_end) state_d = ST_STOP;
            ST_STOP:   if (bit_end && (idx_q == STOP_LAST)) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Bit timer, bit index (data bits, then reused for stop bits) and word capture.
    always_comb begin
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        par_d   = par_q;
        if (state_q == ST_IDLE) begin
            cnt_d = '0;
            idx_d = '0;
        end else begin
            cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
            if (bit_end) begin
                if (state_q == ST_DATA) begin
                    idx_d   = (idx_q == DATA_LAST) ? '0 : idx_q + IDX_W'(1);
                    shift_d = shift_q >> 1;
                end else if (state_q == ST_STOP) begin
                    idx_d = (idx_q == STOP_LAST) ? '0 : idx_q + IDX_W'(1);
                end
            end
        end
        // The word and its parity are frozen at load so val_in cannot disturb a frame.
        if (load) begin
            shift_d = load_word;
            par_d   = (PARITY == PAR_ODD) ? ~(^load_word) : (^load_word);
        end
    end

    // Outputs: the serial level is registered from the current state, so the
    // start bit appears one edge after the accept edge.
    always_comb begin
        line_d    = 1'b1;
        case (state_q)
            ST_IDLE:   line_d = 1'b1;
            ST_START:  line_d = 1'b0;
            ST_DATA:   line_d = shift_q[0];
            ST_PARITY: line_d = par_q;
            ST_STOP:   line_d = 1'b1;
            default:   line_d = 1'b1;
        endcase
        data_out  = line_q;
        busy_out  = (state_q != ST_IDLE);
        state_out = state_q;
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four instances in different configurations,
// a driver task, a per-instance line monitor fed by an expected-frame queue,
// and a summary report.
module tb_uart_tx_param;
    import uart_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT signals ----------------
    // 0: DIV4/8b/EVEN/1 stop  1: DIV4/8b/ODD/1  2: DIV4/8b/NONE/2  3: DIV2/5b/NONE/1
    logic [3:0] valid, ready, line, busy;
    logic [7:0] val_e, val_o, val_n;
    logic [4:0] val_5;
    tx_state_e  st [4];
    int         div_of [4] = '{4, 4, 4, 2};

    uart_tx_param #(.DIVISOR(4), .DATA_BITS(8), .PARITY(PAR_EVEN), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .clk_in(clk), .rst_n_in(rst_n), .val_in(val_e), .valid_in(valid[0]), .ready_out(ready[0]),
        .data_out(line[0]), .busy_out(busy[0]), .state_out(st[0]));
    uart_tx_param #(.DIVISOR(4), .DATA_BITS(8), .PARITY(PAR_ODD), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .clk_in(clk), .rst_n_in(rst_n), .val_in(val_o), .valid_in(valid[1]), .ready_out(ready[1]),
        .data_out(line[1]), .busy_out(busy[1]), .state_out(st[1]));
    uart_tx_param #(.DIVISOR(4), .DATA_BITS(8), .PARITY(PAR_NONE), .STOP_BITS(2), .FIFO_DEPTH(4)) u_none2 (
        .clk_in(clk), .rst_n_in(rst_n), .val_in(val_n), .valid_in(valid[2]), .ready_out(ready[2]),
        .data_out(line[2]), .busy_out(busy[2]), .state_out(st[2]));
    uart_tx_param #(.DIVISOR(2), .DATA_BITS(5), .PARITY(PAR_NONE), .STOP_BITS(1), .FIFO_DEPTH(4)) u_d5 (
        .clk_in(clk), .rst_n_in(rst_n), .val_in(val_5), .valid_in(valid[3]), .ready_out(ready[3]),
        .data_out(line[3]), .busy_out(busy[3]), .state_out(st[3]));

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [22:0] exp_q[$];      // {instance[1:0], length[4:0], bits, first-sent bit at length-1}
    int          abort_cnt [4];
    int          gap [4];
    int          last_acc;
    int          a0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic send(input int i, input logic [7:0] w, input logic [15:0] seq,
                        input int len, input bit hold);
        int t;
        t = 0;
        @(negedge clk);
        case (i)
            0:       val_e = w;
            1:       val_o = w;
            2:       val_n = w;
            default: val_5 = w[4:0];
        endcase
        valid[i] = 1'b1;
        while (ready[i] !== 1'b1 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) begin
            check($sformatf("send_timeout i=%0d", i), 32'(ready[i]), 32'd1);
            valid[i] = 1'b0;
        end else begin
            exp_q.push_back({2'(i), 5'(len), seq});
            @(posedge clk);
            #1;
            last_acc = cyc;
            if (!hold) valid[i] = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || busy != 4'b0000) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- monitor ----------------
    task automatic mon(input int i);
        logic [22:0] e;
        logic [15:0] seq;
        int          len, g, snap;
        bit          ok, aborted;
        forever begin
            g = 0;
            @(negedge clk);
            while (line[i] !== 1'b0) begin
                g++;
                @(negedge clk);
            end
            gap[i] = g;
            if (exp_q.size() == 0 || int'(exp_q[0][22:21]) != i) begin
                checks++;
                errors++;
                $display("FAIL unexpected_frame i=%0d: start bit seen, expected none", i);
                while (busy[i] === 1'b1) @(negedge clk);
            end else begin
                e       = exp_q.pop_front();
                len     = int'(e[20:16]);
                seq     = e[15:0];
                snap    = abort_cnt[i];
                aborted = 1'b0;
                check($sformatf("start_busy i=%0d", i), 32'(busy[i]), 32'd1);
                for (int b = 0; b < len && !aborted; b++) begin
                    ok = 1'b1;
                    for (int k = 0; k < div_of[i] && !aborted; k++) begin
                        if (b != 0 || k != 0) @(negedge clk);
                        if (abort_cnt[i] != snap) aborted = 1'b1;
                        else if (line[i] !== seq[len-1-b]) ok = 1'b0;
                    end
                    if (!aborted)
                        check($sformatf("frame_bit i=%0d bit=%0d want=%0b held_all_clocks", i, b, seq[len-1-b]),
                              32'(ok), 32'd1);
                end
                if (!aborted) check($sformatf("frame_end_idle i=%0d busy", i), 32'(busy[i]), 32'd0);
            end
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
            mon(3);
        join_none
    end

    // busy tracks state; without the FIFO, ready is high only in IDLE.
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            check($sformatf("busy_vs_state i=%0d", i), 32'(busy[i]), 32'(st[i] != ST_IDLE));
`ifndef UART_TX_FIFO_EN
            check($sformatf("ready_vs_state i=%0d", i), 32'(ready[i]), 32'(st[i] == ST_IDLE));
`endif
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        valid = 4'b0000;
        val_e = '0; val_o = '0; val_n = '0; val_5 = '0;
        for (int i = 0; i < 4; i++) abort_cnt[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("reset_line i=%0d", i),  32'(line[i]),  32'd1);
            check($sformatf("reset_busy i=%0d", i),  32'(busy[i]),  32'd0);
            check($sformatf("reset_ready i=%0d", i), 32'(ready[i]), 32'd1);
            check($sformatf("reset_state i=%0d", i), 32'(st[i]),    32'(ST_IDLE));
        end
        rst_n = 1'b1;

        // 5 data bits at DIVISOR 2, plus start latency.
        send(3, 8'h15, 16'b0101011, 7, 1'b0);
`ifndef UART_TX_FIFO_EN
        check("latency_line_on_accept_edge", 32'(line[3]), 32'd1);
        check("latency_busy_after_accept",   32'(busy[3]), 32'd1);
        @(posedge clk);
        #1;
        check("latency_line_next_edge", 32'(line[3]), 32'd0);
`endif
        drain();
        send(3, 8'h0A, 16'b0010101, 7, 1'b0);
        drain();

        // Parity modes and two stop bits on 0xA5 and other words.
        send(0, 8'hA5, 16'b01010010101, 11, 1'b0);
        drain();
        send(1, 8'hA5, 16'b01010010111, 11, 1'b0);
        send(1, 8'h00, 16'b00000000011, 11, 1'b0);
        drain();
        send(2, 8'hA5, 16'b01010010111, 11, 1'b0);
        send(2, 8'h3C, 16'b00011110011, 11, 1'b0);
        drain();

`ifndef UART_TX_FIFO_EN
        // valid_in held high: 0x00 then 0xFF, one idle clock between frames.
        send(0, 8'h00, 16'b00000000001, 11, 1'b1);
        a0 = last_acc;
        send(0, 8'hFF, 16'b01111111101, 11, 1'b0);
        check("b2b_accept_spacing", 32'(last_acc - a0), 32'd45);
        drain();
        check("b2b_idle_gap", 32'(gap[0]), 32'd1);
`endif

        // Reset during data bit 3 of 0x5A; a word offered during reset is ignored.
        send(0, 8'h5A, 16'b00101101001, 11, 1'b0);
        repeat (18) @(negedge clk);
        #1;
        rst_n        = 1'b0;
        abort_cnt[0] = abort_cnt[0] + 1;
        val_o        = 8'h33;
        valid[1]     = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_line",  32'(line[0]),  32'd1);
        check("midreset_busy",  32'(busy[0]),  32'd0);
        check("midreset_ready", 32'(ready[0]), 32'd1);
        check("midreset_state", 32'(st[0]),    32'(ST_IDLE));
        rst_n    = 1'b1;
        valid[1] = 1'b0;
        @(negedge clk);
        check("word_in_reset_not_taken", 32'(busy[1]), 32'd0);
        send(0, 8'h3C, 16'b00011110001, 11, 1'b0);
        drain();

`ifdef UART_TX_FIFO_EN
        // Five back-to-back pushes into a depth-4 FIFO.
        send(0, 8'h01, 16'b01000000011, 11, 1'b1);
        a0 = last_acc;
        send(0, 8'h80, 16'b00000000111, 11, 1'b1);
        send(0, 8'hC3, 16'b01100001101, 11, 1'b1);
        send(0, 8'h7E, 16'b00111111001, 11, 1'b1);
        send(0, 8'h55, 16'b01010101001, 11, 1'b0);
        check("fifo_push_spacing", 32'(last_acc - a0), 32'd4);
        check("fifo_full_ready",   32'(ready[0]), 32'd0);
        drain();
        check("fifo_ready_after_drain", 32'(ready[0]), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter DIVISOR, default 868, SHALL set clocks per bit (legal range >= 2).
REQ-003 Parameter DATA_BITS, default 8, SHALL set data bits per frame (legal range 5..9).
REQ-004 Parameter PARITY, default PAR_NONE, SHALL select the parity mode: PAR_NONE, PAR_ODD or PAR_EVEN.
REQ-005 Parameter STOP_BITS, default 1, SHALL set stop bits per frame (legal values 1 or 2).
REQ-006 Parameter FIFO_DEPTH, default 8, SHALL set the FIFO depth, a power of 2 >= 2; it is used only when UART_TX_FIFO_EN is defined.
REQ-007 Port clk_in, input, width 1: the system clock.
REQ-008 Port rst_n_in, input, width 1: synchronous reset, active low.
REQ-009 Port val_in, input, width DATA_BITS: the word to send.
REQ-010 Port valid_in, input, width 1: val_in is valid.
REQ-011 Port ready_out, output, width 1: the block can accept a word.
REQ-012 Port data_out, output, width 1: the serial line, idle high.
REQ-013 Port busy_out, output, width 1: a frame is in progress.

Function
REQ-014 A word SHALL be accepted on any rising edge where valid_in && ready_out; val_in SHALL be captured on that edge.
REQ-015 The frame SHALL be sent in this order: start bit (0), then DATA_BITS data bits LSB first, then the optional parity bit, then STOP_BITS stop bits (1).
REQ-016 Each bit SHALL be held on data_out for exactly DIVISOR clocks, timed by a bit counter that wraps from DIVISOR-1 to 0.
REQ-017 The parity bit SHALL be the XOR of the data bits for PAR_EVEN and the inverted XOR for PAR_ODD; no parity bit SHALL be sent for PAR_NONE.
REQ-018 The state machine SHALL have states IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on accept (or, in FIFO mode, on a pop).
- START -> DATA after DIVISOR clocks.
- DATA -> PARITY, or -> STOP when parity is none, after DATA_BITS bits.
- PARITY -> STOP after DIVISOR clocks.
- STOP -> IDLE after STOP_BITS*DIVISOR clocks.
REQ-019 Latency: data_out SHALL go low on the first clock edge after the accept (or pop) edge.
REQ-020 data_out SHALL be 1 in IDLE, and IDLE SHALL last at least one clock between frames.
REQ-021 busy_out SHALL be 1 in every state except IDLE.
REQ-022 Without the FIFO, ready_out SHALL be 1 only in IDLE, so back-to-back frames are separated by exactly one idle clock while valid_in is held high.
REQ-023 val_in SHALL have no effect on a frame in progress.
REQ-024 data_out SHALL be registered, with no combinational path from any input.

Reset
REQ-025 With rst_n_in low at a clock edge, the following SHALL hold on that edge, including mid-frame:
- data_out=1, busy_out=0, ready_out=1;
- state=IDLE, counters=0;
- FIFO emptied.
REQ-026 A word presented while rst_n_in is low SHALL NOT be accepted.

Configuration
REQ-027 Macro UART_TX_FIFO_EN SHALL control the transmit FIFO.
REQ-028 With UART_TX_FIFO_EN defined:
- a FIFO of depth FIFO_DEPTH SHALL sit in front of the transmitter, with ready_out = !full;
- the transmitter SHALL pop in IDLE when the FIFO is not empty;
- a push and a pop on the same edge SHALL both succeed, with the count unchanged;
- a push while full SHALL be blocked by ready_out=0.
REQ-029 Without UART_TX_FIFO_EN, the block SHALL have no FIFO logic and SHALL behave per REQ-022.

Structure
REQ-030 Package uart_pkg SHALL hold the parity enum (PAR_NONE, PAR_ODD, PAR_EVEN), the tx state enum, and the localparam for frame-length arithmetic.
REQ-031 Sub-module uart_tx_fifo (synchronous FIFO, with full/empty flags and wrap-around pointers) SHALL be instantiated only under UART_TX_FIFO_EN.
REQ-032 The bit counter SHALL be $clog2(DIVISOR) bits wide, and the bit index SHALL be $clog2(DATA_BITS+1) bits wide.

Verification
REQ-033 The bench SHALL cover these directed scenarios:
- DIVISOR=4, DATA_BITS=8, PAR_EVEN, 1 stop; send 0xA5 -> data_out sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 4 clocks, 44 clocks total, then idle high.
- Same configuration with PAR_ODD; send 0xA5 -> parity bit 1; with PAR_NONE and STOP_BITS=2 -> 11 bits, last two high, 44 clocks.
- No FIFO, valid_in held high with 0x00 then 0xFF -> exactly one idle clock between frames; ready_out=1 only in IDLE.
- rst_n_in low during data bit 3 -> data_out=1, busy_out=0 on that edge; the next accepted word is sent as a full, correct frame.
- UART_TX_FIFO_EN with FIFO_DEPTH=4: push 5 words back-to-back -> ready_out drops after 4 (plus 1 once the first pop frees a slot), all words sent in order, no loss.
- DATA_BITS=5, DIVISOR=2; send 0x15 -> data_out sequence 0,1,0,1,0,1,1, each bit 2 clocks.
